pipeline_skid_buffer: RTL

// - Elastic pipeline stage register with valid/ready handshake on both sides; the stall-aware counterpart to the

---
 rtl/pipeline_skid_buffer_pkg.sv | 12 +
 rtl/pipeline_skid_buffer.sv | 89 ++++++++
 2 files changed

// File: rtl/pipeline_skid_buffer_pkg.sv
// Shared definitions for the elastic skid-buffer stage: state encoding doubles as occupancy.
package pipeline_skid_buffer_pkg;

   typedef enum logic [1:0] {
      PSB_EMPTY = 2'b00,
      PSB_BUSY  = 2'b01,
      PSB_FULL  = 2'b10
   } psb_state_e;

   localparam int unsigned PSB_DEPTH = 2;

endpackage

// File: rtl/pipeline_skid_buffer.sv
// Two-entry elastic stage register (main + skid) with registered in_ready and synchronous flush.
// Head entry always sits in main; skid only ever holds the younger entry.
module pipeline_skid_buffer
   import pipeline_skid_buffer_pkg::*;
#(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   psb_state_e       state, state_nxt;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             load_main, main_from_skid, load_skid;
   logic             in_fire, out_fire;

   assign out_valid = (state != PSB_EMPTY);
   assign in_ready  = (state != PSB_FULL);
   assign occupancy = state;
   assign out_data  = main_q;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = PSB_EMPTY;
      end else begin
         case (state)
            PSB_EMPTY: begin
               if (in_fire) begin
                  state_nxt = PSB_BUSY;
                  load_main = 1'b1;
               end
            end
            PSB_BUSY: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  state_nxt = PSB_FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_nxt = PSB_EMPTY;
               end
            end
            PSB_FULL: begin
               // in_ready is low here, so only the drain side can move
               if (out_fire) begin
                  state_nxt      = PSB_BUSY;
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_nxt = PSB_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= PSB_EMPTY;
         main_q <= RESET_DATA;
         skid_q <= RESET_DATA;
      end else begin
         state <= state_nxt;
         if (flush) begin
            main_q <= RESET_DATA;
            skid_q <= RESET_DATA;
         end else begin
            if (load_main) main_q <= main_from_skid ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
         end
      end
   end

endmodule
